siso_frame_ctrl: RTL and testbench

Sequencer for the serial-in/serial-out D-flip-flop delay chain. Accepts a parallel word over a valid/ready handshake and shifts it MSB-first into a DEPTH-stage shift chain. It then recaptures the bits emerging at the chain output into a parallel word and returns that word with a match flag. The block serves as the frame-level controller and loopback checker for serial shift datapaths.

---
 rtl/siso_pkg.sv | 14 +
 rtl/siso_chain.sv | 31 +++
 rtl/siso_frame_ctrl.sv | 95 +++++++++
 tb/tb_siso_frame_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/siso_pkg.sv
// Shared types and defaults for the serial-in/serial-out frame controller.
// Holds the FSM state type and the default frame width and chain depth.
package siso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } siso_state_t;

  localparam int SISO_WIDTH = 8;
  localparam int SISO_DEPTH = 4;

endpackage

// File: rtl/siso_chain.sv
// DEPTH-stage D flip-flop delay chain. Latency is DEPTH enabled cycles from Din to Sout.
// No backpressure: it shifts when en is high and holds otherwise.
module siso_chain #(
  parameter int DEPTH = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  input  logic Din,
  output logic Sout
);

  logic [DEPTH-1:0] stage;
  logic [DEPTH-1:0] stage_next;

  always_comb begin
    stage_next    = stage << 1;
    stage_next[0] = Din;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stage <= '0;
    end else if (en) begin
      stage <= stage_next;
    end
  end

  assign Sout = stage[DEPTH-1];

endmodule

// File: rtl/siso_frame_ctrl.sv
// Serializes an accepted word MSB-first through siso_chain and recaptures it. The result appears WIDTH+DEPTH cycles after accept.
// The result is held in DONE until out_ready is seen. A new word is accepted only in IDLE.
module siso_frame_ctrl
  import siso_pkg::*;
#(
  parameter int WIDTH = SISO_WIDTH,
  parameter int DEPTH = SISO_DEPTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             Din,
  output logic             Sout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             match,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + DEPTH + 1);
  localparam logic [CW-1:0] CNT_W    = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_D    = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH + DEPTH - 1);

  siso_state_t      state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] tx_sh;
  logic [WIDTH-1:0] rx_sh;
  logic [WIDTH-1:0] rx_next;
  logic [WIDTH-1:0] word_q;
  logic             chain_en;
  logic             din_bit;
  logic             sout_bit;

  assign chain_en = (state == SHIFT);
  // Zeros follow the last data bit so the chain is flushed clean by DONE.
  assign din_bit  = (chain_en && (cnt < CNT_W)) ? tx_sh[WIDTH-1] : 1'b0;

  always_comb begin
    rx_next    = rx_sh << 1;
    rx_next[0] = sout_bit;
  end

  siso_chain #(.DEPTH(DEPTH)) u_chain (
    .CLK  (CLK),
    .RST  (RST),
    .en   (chain_en),
    .Din  (din_bit),
    .Sout (sout_bit)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      tx_sh  <= '0;
      rx_sh  <= '0;
      word_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            tx_sh  <= in_data;
            word_q <= in_data;
            rx_sh  <= '0;
            cnt    <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          tx_sh <= tx_sh << 1;
          cnt   <= cnt + 1'b1;
          if (cnt >= CNT_D) rx_sh <= rx_next;
          if (cnt == CNT_LAST) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = chain_en;
  assign out_valid = (state == DONE);
  assign out_data  = out_valid ? rx_sh : '0;
  assign match     = out_valid && (rx_sh == word_q);
  assign Din       = din_bit;
  assign Sout      = sout_bit;

endmodule

// File: tb/tb_siso_frame_ctrl.sv
// Directed bench for siso_frame_ctrl: default 8/4 instance plus 1/1 and 16/7 sweeps.
module tb_siso_frame_ctrl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST;
  logic       in_valid, in_ready, Din, Sout, out_valid, out_ready, match, busy;
  logic [7:0] in_data, out_data;

  logic       a_iv, a_ir, a_din, a_sout, a_ov, a_or, a_m, a_busy;
  logic [0:0] a_id, a_od;
  logic       b_iv, b_ir, b_din, b_sout, b_ov, b_or, b_m, b_busy;
  logic [15:0] b_id, b_od;

  siso_frame_ctrl #(.WIDTH(8), .DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .Din(Din), .Sout(Sout), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .match(match), .busy(busy)
  );

  siso_frame_ctrl #(.WIDTH(1), .DEPTH(1)) dut_a (
    .CLK(CLK), .RST(RST), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .Din(a_din), .Sout(a_sout), .out_valid(a_ov), .out_ready(a_or),
    .out_data(a_od), .match(a_m), .busy(a_busy)
  );

  siso_frame_ctrl #(.WIDTH(16), .DEPTH(7)) dut_b (
    .CLK(CLK), .RST(RST), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .Din(b_din), .Sout(b_sout), .out_valid(b_ov), .out_ready(b_or),
    .out_data(b_od), .match(b_m), .busy(b_busy)
  );

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_out;
    logic       exp_match;
  } vec_t;

  vec_t tbl [6];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int acc_q [$];
  logic [7:0] od_q [$];
  logic m_q [$];
  bit ov_seen = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK) begin
    if (!RST && in_valid && in_ready) acc_q.push_back(cyc);
    if (out_valid && out_ready) begin
      od_q.push_back(out_data);
      m_q.push_back(match);
    end
    if (out_valid) ov_seen = 1'b1;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic start(input logic [7:0] d);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic shift_check(input logic [7:0] d);
    for (int k = 0; k < 12; k++) begin
      chk("busy_shift", {31'd0, busy}, 32'd1);
      chk("in_ready_shift", {31'd0, in_ready}, 32'd0);
      chk("out_valid_shift", {31'd0, out_valid}, 32'd0);
      chk("match_shift", {31'd0, match}, 32'd0);
      chk("din_bit", {31'd0, Din}, (k < 8) ? {31'd0, d[7-k]} : 32'd0);
      chk("sout_bit", {31'd0, Sout}, (k >= 4) ? {31'd0, d[11-k]} : 32'd0);
      tick();
    end
  endtask

  task automatic done_check(input logic [7:0] d);
    chk("out_valid_done", {31'd0, out_valid}, 32'd1);
    chk("out_data_done", {24'd0, out_data}, {24'd0, d});
    chk("match_done", {31'd0, match}, 32'd1);
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("in_ready_done", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_released", {31'd0, out_valid}, 32'd0);
    chk("in_ready_released", {31'd0, in_ready}, 32'd1);
    chk("sout_flushed", {31'd0, Sout}, 32'd0);
  endtask

  initial begin
    int n0;
    int wait_cnt;
    int lat;
    logic [0:0]  da;
    logic [15:0] db;

    tbl[0] = '{data: 8'hA5, exp_out: 8'hA5, exp_match: 1'b1};
    tbl[1] = '{data: 8'h01, exp_out: 8'h01, exp_match: 1'b1};
    tbl[2] = '{data: 8'h80, exp_out: 8'h80, exp_match: 1'b1};
    tbl[3] = '{data: 8'hC3, exp_out: 8'hC3, exp_match: 1'b1};
    tbl[4] = '{data: 8'h5A, exp_out: 8'h5A, exp_match: 1'b1};
    tbl[5] = '{data: 8'hFF, exp_out: 8'hFF, exp_match: 1'b1};

    RST = 1'b1;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    a_iv = 1'b0; a_id = 1'b0; a_or = 1'b0;
    b_iv = 1'b0; b_id = 16'h0; b_or = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sout", {31'd0, Sout}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_din", {31'd0, Din}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_match", {31'd0, match}, 32'd0);

    // Table-driven single frames with exact latency and bit timing.
    for (int i = 0; i < 6; i++) begin
      start(tbl[i].data);
      shift_check(tbl[i].data);
      chk("tbl_out_data", {24'd0, out_data}, {24'd0, tbl[i].exp_out});
      chk("tbl_match", {31'd0, match}, {31'd0, tbl[i].exp_match});
      chk("tbl_out_valid", {31'd0, out_valid}, 32'd1);
      release_out();
    end

    // Back-pressure: DONE held 5 cycles while a new word is offered.
    start(8'h96);
    shift_check(8'h96);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    n0 = acc_q.size();
    for (int i = 0; i < 5; i++) begin
      done_check(8'h96);
      tick();
    end
    chk("bp_no_accept", n0, acc_q.size());
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_idle_after_release", {31'd0, in_ready}, 32'd1);
    chk("bp_still_no_accept", n0, acc_q.size());
    tick();
    in_valid = 1'b0;
    chk("bp_accept_in_idle", n0 + 1, acc_q.size());
    shift_check(8'h3C);
    done_check(8'h3C);
    release_out();

    // Back-to-back frames with out_ready tied high.
    acc_q.delete(); od_q.delete(); m_q.delete();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    tick();
    in_data   = 8'h00;
    wait_cnt  = 0;
    while (acc_q.size() < 2 && wait_cnt < 100) begin
      tick();
      wait_cnt++;
    end
    in_valid = 1'b0;
    wait_cnt = 0;
    while (od_q.size() < 2 && wait_cnt < 100) begin
      tick();
      wait_cnt++;
    end
    out_ready = 1'b0;
    if (acc_q.size() == 2 && od_q.size() == 2) begin
      chk("b2b_period", acc_q[1] - acc_q[0], 32'd14);
      chk("b2b_data0", {24'd0, od_q[0]}, 32'hFF);
      chk("b2b_match0", {31'd0, m_q[0]}, 32'd1);
      chk("b2b_data1", {24'd0, od_q[1]}, 32'h00);
      chk("b2b_match1", {31'd0, m_q[1]}, 32'd1);
    end else begin
      chk("b2b_timeout", acc_q.size() * 16 + od_q.size(), 32'd34);
    end

    // Reset in the middle of a frame.
    start(8'h81);
    repeat (5) tick();
    RST = 1'b1;
    ov_seen = 1'b0;
    tick();
    RST = 1'b0;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_sout", {31'd0, Sout}, 32'd0);
    chk("mid_rst_din", {31'd0, Din}, 32'd0);
    chk("mid_rst_out_data", {24'd0, out_data}, 32'd0);
    repeat (20) tick();
    chk("mid_rst_no_out_valid", {31'd0, ov_seen}, 32'd0);
    start(8'h7E);
    shift_check(8'h7E);
    done_check(8'h7E);
    release_out();

    // WIDTH=1 / DEPTH=1 sweep.
    for (int f = 0; f < 100; f++) begin
      da = 1'($urandom);
      a_iv = 1'b1; a_id = da;
      tick();
      a_iv = 1'b0;
      lat = 0;
      while (!a_ov && lat < 64) begin
        tick();
        lat++;
      end
      chk("w1_latency", lat, 32'd2);
      chk("w1_data", {31'd0, a_od}, {31'd0, da});
      chk("w1_match", {31'd0, a_m}, 32'd1);
      a_or = 1'b1;
      tick();
      a_or = 1'b0;
    end

    // WIDTH=16 / DEPTH=7 sweep.
    for (int f = 0; f < 100; f++) begin
      db = 16'($urandom);
      b_iv = 1'b1; b_id = db;
      tick();
      b_iv = 1'b0;
      lat = 0;
      while (!b_ov && lat < 64) begin
        tick();
        lat++;
      end
      chk("w16_latency", lat, 32'd23);
      chk("w16_data", {16'd0, b_od}, {16'd0, db});
      chk("w16_match", {31'd0, b_m}, 32'd1);
      b_or = 1'b1;
      tick();
      b_or = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
